// File: rtl/vdec_pkg.sv
// Shared constants and helpers for the K=3, rate-1/2 (7,5) Viterbi decoder.
// Optional feature macro: VDEC_ERRCNT_EN (corrected-symbol counter on the top level).
package vdec_pkg;

  localparam logic [2:0]  G0      = 3'b111;
  localparam logic [2:0]  G1      = 3'b101;
  localparam int unsigned NSTATES = 4;
  localparam int unsigned INIT_PM = 4;

  // Expected {c0,c1} when input u is applied in state {u[t-1],u[t-2]}.
  function automatic logic [1:0] exp_sym(input logic [1:0] state, input logic u);
    logic [2:0] taps;
    taps = {u, state};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

  // Hamming distance between two 2-bit symbols (0..2).
  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

endpackage

// File: rtl/vdec_acs.sv
// Add-compare-select for one trellis state: two predecessor metrics plus their branch
// metrics in, new (pre-normalisation) metric and winner select out.
module vdec_acs
  import vdec_pkg::*;
#(
  parameter int unsigned PM_WIDTH = 6
) (
  input  logic [PM_WIDTH-1:0] pm_a,
  input  logic [1:0]          bm_a,
  input  logic [PM_WIDTH-1:0] pm_b,
  input  logic [1:0]          bm_b,
  output logic [PM_WIDTH:0]   pm_new,
  output logic                sel
);

  logic [PM_WIDTH:0] sum_a;
  logic [PM_WIDTH:0] sum_b;

  // One extra bit of headroom so the add never wraps; ties keep predecessor a.
  always_comb begin
    sum_a  = {1'b0, pm_a} + {{(PM_WIDTH - 1){1'b0}}, bm_a};
    sum_b  = {1'b0, pm_b} + {{(PM_WIDTH - 1){1'b0}}, bm_b};
    sel    = (sum_b < sum_a);
    pm_new = sel ? sum_b : sum_a;
  end

endmodule

// File: rtl/vdecoder.sv
// Hard-decision Viterbi decoder for the serial (7,5) coded stream from vencoder.
// Register-exchange survivors, fixed decode latency of TB_DEPTH symbols.
// Define VDEC_ERRCNT_EN to add the err_cnt port and its saturating counter.
module vdecoder
  import vdec_pkg::*;
#(
  parameter int unsigned TB_DEPTH = 15,
  parameter int unsigned PM_WIDTH = 6
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic        in,
  output logic        out,
  output logic        out_vld
`ifdef VDEC_ERRCNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int unsigned      CntW = $clog2(TB_DEPTH + 1);
  localparam logic [PM_WIDTH:0] Half = {2'b01, {(PM_WIDTH - 1){1'b0}}};

  logic                phase_q;
  logic                c0_q;
  logic [1:0]          sym;
  logic [PM_WIDTH-1:0] pm_q     [NSTATES];
  logic [PM_WIDTH-1:0] pm_d     [NSTATES];
  logic [PM_WIDTH:0]   pm_new   [NSTATES];
  logic [1:0]          bm_a     [NSTATES];
  logic [1:0]          bm_b     [NSTATES];
  logic [NSTATES-1:0]  sel;
  // The oldest survivor bit is only ever consumed as the output, so registers keep
  // TB_DEPTH-1 bits and the full TB_DEPTH-bit survivor exists combinationally.
  logic [TB_DEPTH-2:0] surv_q   [NSTATES];
  logic [TB_DEPTH-2:0] surv_d   [NSTATES];
  logic [TB_DEPTH-1:0] surv_full[NSTATES];
  logic [1:0]          best_lo;
  logic [1:0]          best_hi;
  logic [1:0]          best;
  logic                all_high;
  logic [CntW-1:0]     fill_q;
  logic [CntW-1:0]     fill_d;
  logic                out_q;
  logic                out_d;
  logic                vld_q;
  logic                vld_d;

  assign sym = {c0_q, in};

  // New state n={u,s1}: predecessors are {n[0],0} (lower) and {n[0],1}, input bit is n[1].
  for (genvar n = 0; n < NSTATES; n++) begin : gen_acs
    localparam logic [1:0] P0 = 2'((n % 2) * 2);
    localparam logic [1:0] P1 = 2'((n % 2) * 2 + 1);
    localparam logic       U  = 1'(n / 2);

    assign bm_a[n] = hamming2(exp_sym(P0, U), sym);
    assign bm_b[n] = hamming2(exp_sym(P1, U), sym);

    vdec_acs #(
      .PM_WIDTH(PM_WIDTH)
    ) u_acs (
      .pm_a  (pm_q[P0]),
      .bm_a  (bm_a[n]),
      .pm_b  (pm_q[P1]),
      .bm_b  (bm_b[n]),
      .pm_new(pm_new[n]),
      .sel   (sel[n])
    );

    assign surv_full[n] = {(sel[n] ? surv_q[P1] : surv_q[P0]), U};
  end

  // Best-state min tree; ties resolve to the lowest state index.
  always_comb begin
    best_lo = (pm_new[1] < pm_new[0]) ? 2'd1 : 2'd0;
    best_hi = (pm_new[3] < pm_new[2]) ? 2'd3 : 2'd2;
    best    = (pm_new[best_hi] < pm_new[best_lo]) ? best_hi : best_lo;
  end

  // Next-state: metrics, survivors, fill and output only move on the symbol edge.
  always_comb begin
    all_high = 1'b1;
    for (int unsigned i = 0; i < NSTATES; i++) begin
      if (pm_new[i] < Half) all_high = 1'b0;
    end
    pm_d   = pm_q;
    surv_d = surv_q;
    fill_d = fill_q;
    out_d  = out_q;
    vld_d  = 1'b0;
    if (phase_q) begin
      for (int unsigned i = 0; i < NSTATES; i++) begin
        pm_d[i]   = all_high ? PM_WIDTH'(pm_new[i] - Half) : PM_WIDTH'(pm_new[i]);
        surv_d[i] = surv_full[i][TB_DEPTH-2:0];
      end
      fill_d = (fill_q == CntW'(TB_DEPTH)) ? fill_q : fill_q + CntW'(1);
      vld_d  = (fill_d == CntW'(TB_DEPTH));
      if (vld_d) out_d = surv_full[best][TB_DEPTH-1];
    end
  end

  // State registers; c0 is captured on the phase-0 edge.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      phase_q <= 1'b0;
      c0_q    <= 1'b0;
      for (int unsigned i = 0; i < NSTATES; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_WIDTH'(INIT_PM);
        surv_q[i] <= '0;
      end
      fill_q  <= '0;
      out_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      phase_q <= ~phase_q;
      if (!phase_q) c0_q <= in;
      pm_q    <= pm_d;
      surv_q  <= surv_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  assign out     = out_q;
  assign out_vld = vld_q;

`ifdef VDEC_ERRCNT_EN
  logic [15:0] err_q;
  logic [15:0] err_d;
  logic [1:0]  bm_win;

  // Count symbols whose winning branch into the best state was not error-free.
  always_comb begin
    bm_win = sel[best] ? bm_b[best] : bm_a[best];
    err_d  = err_q;
    if (phase_q && (bm_win != 2'd0) && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
  end

  // Error counter register.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_cnt = err_q;
`endif

endmodule
